store_stage: RTL
================

Name: store_stage

Overview:
- Final pipeline stage of each core; the receiving end of the execute-to-store bus.
- Consumes one storage packet at a time and performs its side effect:
  - register writeback, with the destination marked valid again;
  - vector memory load or store;
  - PC redirect to fetch (single or split/divergent);
  - halt.
- Counts retired packets for the global stats block.

Parameters:
CORE_ID, 0, core index used in debug display text
NUM_THREADS, 8, SIMD lanes; execution-mask width
WORD_W, 64, bits per lane and per address
REG_ID_W, 5, register index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  packet offered by execute
in_ready  out  1  store stage can accept a packet
in_kind  in  3  storage_kind_t: NONE/HALT, JMP, CJMP, LOAD_MEM_INTO_REG, STORE_VALUE_INTO_REG, STORE_REG_INTO_MEM
in_exec_mask  in  NUM_THREADS  active lanes
in_pc  in  WORD_W  PC of the originating instruction
in_reg_id  in  REG_ID_W  destination register
in_vec_a  in  NUM_THREADS*WORD_W  value, or address vector for memory kinds
in_vec_b  in  NUM_THREADS*WORD_W  store data
in_addr0/in_addr1  in  WORD_W  jump targets (taken / fallthrough)
in_mask0/in_mask1  in  NUM_THREADS  lane masks for the two CJMP targets
in_restore_pc  in  1  load is a PC restore
rf_wr_en  out  1  register write strobe
rf_wr_reg  out  REG_ID_W  register written
rf_wr_data  out  NUM_THREADS*WORD_W  data written
rf_wr_mask  out  NUM_THREADS  lane write enables; the write also marks the register valid
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts the request
mem_req_we  out  1  1 = store
mem_req_addr  out  NUM_THREADS*WORD_W  per-lane addresses
mem_req_wdata  out  NUM_THREADS*WORD_W  per-lane store data
mem_req_mask  out  NUM_THREADS  active lanes
mem_rsp_valid  in  1  load data, or store acknowledge
mem_rsp_data  in  NUM_THREADS*WORD_W  load data
fetch_valid  out  1  redirect request
fetch_ready  in  1  fetch accepts the redirect
fetch_split  out  1  two targets present
fetch_pc0/fetch_pc1  out  WORD_W  redirect targets
fetch_mask0/fetch_mask1  out  NUM_THREADS  lane masks for the two targets
halted  out  1  sticky halt indication
proto_err  out  1  sticky error: unknown kind, or unexpected response
retired_cnt  out  32  packets completed; wraps at 2^32

Behaviour:
- Reset (asynchronous, rst_n low): FSM in IDLE. All outputs 0 except in_ready, which is 1. Any in-flight request or write is abandoned.
- FSM states: IDLE, MEM_REQ, MEM_WAIT, REDIRECT, HALTED.
- in_ready = 1 only in IDLE. A packet is accepted on in_valid & in_ready and its fields are registered.
- STORE_VALUE_INTO_REG:
  - FSM stays in IDLE.
  - rf_wr_en is a one-cycle pulse in the cycle after accept, carrying rf_wr_reg = reg_id, rf_wr_data = vec_a, rf_wr_mask = exec_mask.
  - Back-to-back packets are allowed (one per cycle).
- LOAD_MEM_INTO_REG:
  - MEM_REQ: mem_req_valid = 1, we = 0, addr = vec_a, mask = exec_mask. Held stable until mem_req_ready.
  - MEM_WAIT: wait for mem_rsp_valid.
  - On the response cycle, rf_wr_en pulses with mem_rsp_data, masked by exec_mask, in the next cycle.
  - If restore_pc = 1: go to REDIRECT with fetch_pc0 = the lane of rsp data at the lowest set exec_mask bit, fetch_mask0 = exec_mask, split = 0. Otherwise go to IDLE.
- STORE_REG_INTO_MEM: MEM_REQ with we = 1, addr = vec_a, wdata = vec_b. Then MEM_WAIT for the acknowledge (mem_rsp_valid). Then IDLE.
- JMP: REDIRECT with pc0 = addr0, mask0 = exec_mask, split = 0.
- CJMP:
  - REDIRECT with split = 1 and both targets/masks as given.
  - If mask1 == 0, degrade to JMP to addr0.
  - If mask0 == 0, degrade to JMP to addr1 with mask1.
- REDIRECT: fetch_valid is held with stable payload until fetch_ready, then IDLE.
- NONE/HALT: go to HALTED. halted = 1 from the next cycle; in_ready = 0 until reset.
- exec_mask == 0 on any kind except HALT: the packet retires in one cycle with no write, memory, or fetch activity.
- Unknown kind: packet dropped and counted as retired; proto_err set; FSM stays in IDLE.
- mem_rsp_valid outside MEM_WAIT is ignored and sets proto_err.
- retired_cnt increments by 1 in the cycle a packet completes:
  - reg write issued;
  - memory acknowledge received (store);
  - redirect handshake completes;
  - HALTED entered.

Decomposition:
- Shared core package holds:
  - storage_kind_t encoding;
  - REG_PC and REG_FLAGS constants;
  - execution_mask_t;
  - vector lane-slice helper.
- One sub-module: lowest_lane_select (priority encoder plus lane mux), used for the restore-PC target.

Test Plan:
- Back-to-back STORE_VALUE_INTO_REG to reg 3 then reg 4, mask 8'hFF, vec_a lanes = 1..8 -> rf_wr_en high 2 consecutive cycles; data matches; retired_cnt = 2.
- LOAD_MEM_INTO_REG, mem_req_ready delayed 3 cycles, response after 2 more -> request held stable; one write with rsp data, mask 8'h0F; in_ready low throughout.
- Restore-PC load, exec_mask 8'b0000_0100, rsp lane2 = 64'h1000 -> fetch_pc0 = 64'h1000, split = 0 after the register write.
- CJMP addr0 = 0x40, addr1 = 0x20, mask0 = 8'h0F, mask1 = 8'hF0, fetch_ready stalled 4 cycles -> split = 1, payload stable, then IDLE. Repeat with mask1 = 0 -> split = 0, pc0 = 0x40.
- HALT, then further valid packets -> halted = 1, in_ready stays 0, retired_cnt +1 only. Assert rst_n mid MEM_WAIT -> all outputs reset, no stray rf_wr_en.
- Unknown kind 3'b111, and mem_rsp_valid pulsed in IDLE -> proto_err = 1 sticky, no writes.

Source files
------------

// File: rtl/store_stage_pkg.sv
// Shared definitions for the store stage: packet kinds, FSM states,
// special register ids and vector lane helpers.
package store_stage_pkg;

   localparam int unsigned DEF_THREADS  = 8;
   localparam int unsigned DEF_WORD_W   = 64;
   localparam int unsigned DEF_REG_ID_W = 5;

   typedef enum logic [2:0] {
      SK_NONE_HALT            = 3'd0,
      SK_JMP                  = 3'd1,
      SK_CJMP                 = 3'd2,
      SK_LOAD_MEM_INTO_REG    = 3'd3,
      SK_STORE_VALUE_INTO_REG = 3'd4,
      SK_STORE_REG_INTO_MEM   = 3'd5
   } storage_kind_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_MEM_REQ  = 3'd1,
      ST_MEM_WAIT = 3'd2,
      ST_REDIRECT = 3'd3,
      ST_HALTED   = 3'd4
   } store_state_t;

   localparam logic [DEF_REG_ID_W-1:0] REG_PC    = 5'd31;
   localparam logic [DEF_REG_ID_W-1:0] REG_FLAGS = 5'd30;

   typedef logic [DEF_THREADS-1:0]            execution_mask_t;
   typedef logic [DEF_THREADS*DEF_WORD_W-1:0] vec_t;

   function automatic logic [DEF_WORD_W-1:0] lane_slice(input vec_t vec, input int unsigned lane);
      return vec[lane*DEF_WORD_W +: DEF_WORD_W];
   endfunction

endpackage

// File: rtl/store_stage_lowest_lane.sv
// Picks the lane of a vector at the lowest set bit of a lane mask
// (lane 0 when the mask is empty).
module lowest_lane_select #(
   parameter int unsigned NUM_THREADS = 8,
   parameter int unsigned WORD_W      = 64
) (
   input  logic [NUM_THREADS-1:0]        mask_i,
   input  logic [NUM_THREADS*WORD_W-1:0] vec_i,
   output logic [WORD_W-1:0]             lane_o
);
   localparam int unsigned IDX_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

   logic [IDX_W-1:0] idx_s;

   // Priority encoder: scanning downwards leaves the lowest set lane.
   always_comb begin
      idx_s = '0;
      for (int i = NUM_THREADS - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            idx_s = IDX_W'(i);
         end else begin
            idx_s = idx_s;
         end
      end
   end

   assign lane_o = vec_i[idx_s*WORD_W +: WORD_W];

endmodule

// File: rtl/store_stage.sv
// Final pipeline stage: retires execute packets as register writes,
// vector memory accesses, fetch redirects or a halt.
module store_stage
   import store_stage_pkg::*;
#(
   parameter int unsigned CORE_ID     = 0,
   parameter int unsigned NUM_THREADS = 8,
   parameter int unsigned WORD_W      = 64,
   parameter int unsigned REG_ID_W    = 5
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [2:0]                    in_kind,
   input  logic [NUM_THREADS-1:0]        in_exec_mask,
   input  logic [WORD_W-1:0]             in_pc,
   input  logic [REG_ID_W-1:0]           in_reg_id,
   input  logic [NUM_THREADS*WORD_W-1:0] in_vec_a,
   input  logic [NUM_THREADS*WORD_W-1:0] in_vec_b,
   input  logic [WORD_W-1:0]             in_addr0,
   input  logic [WORD_W-1:0]             in_addr1,
   input  logic [NUM_THREADS-1:0]        in_mask0,
   input  logic [NUM_THREADS-1:0]        in_mask1,
   input  logic                          in_restore_pc,
   output logic                          rf_wr_en,
   output logic [REG_ID_W-1:0]           rf_wr_reg,
   output logic [NUM_THREADS*WORD_W-1:0] rf_wr_data,
   output logic [NUM_THREADS-1:0]        rf_wr_mask,
   output logic                          mem_req_valid,
   input  logic                          mem_req_ready,
   output logic                          mem_req_we,
   output logic [NUM_THREADS*WORD_W-1:0] mem_req_addr,
   output logic [NUM_THREADS*WORD_W-1:0] mem_req_wdata,
   output logic [NUM_THREADS-1:0]        mem_req_mask,
   input  logic                          mem_rsp_valid,
   input  logic [NUM_THREADS*WORD_W-1:0] mem_rsp_data,
   output logic                          fetch_valid,
   input  logic                          fetch_ready,
   output logic                          fetch_split,
   output logic [WORD_W-1:0]             fetch_pc0,
   output logic [WORD_W-1:0]             fetch_pc1,
   output logic [NUM_THREADS-1:0]        fetch_mask0,
   output logic [NUM_THREADS-1:0]        fetch_mask1,
   output logic                          halted,
   output logic                          proto_err,
   output logic [31:0]                   retired_cnt
);
   localparam int unsigned VEC_W = NUM_THREADS * WORD_W;

   store_state_t             state_q, state_d;
   logic [NUM_THREADS-1:0]   mask_q, mask_d;
   logic [REG_ID_W-1:0]      reg_q, reg_d;
   logic                     restore_q, restore_d;
   logic                     rf_wr_en_q, rf_wr_en_d;
   logic [REG_ID_W-1:0]      rf_wr_reg_q, rf_wr_reg_d;
   logic [VEC_W-1:0]         rf_wr_data_q, rf_wr_data_d;
   logic [NUM_THREADS-1:0]   rf_wr_mask_q, rf_wr_mask_d;
   logic                     mem_valid_q, mem_valid_d;
   logic                     mem_we_q, mem_we_d;
   logic [VEC_W-1:0]         mem_addr_q, mem_addr_d;
   logic [VEC_W-1:0]         mem_wdata_q, mem_wdata_d;
   logic [NUM_THREADS-1:0]   mem_mask_q, mem_mask_d;
   logic                     fe_valid_q, fe_valid_d;
   logic                     fe_split_q, fe_split_d;
   logic [WORD_W-1:0]        fe_pc0_q, fe_pc0_d, fe_pc1_q, fe_pc1_d;
   logic [NUM_THREADS-1:0]   fe_mask0_q, fe_mask0_d, fe_mask1_q, fe_mask1_d;
   logic                     halted_q, halted_d;
   logic                     proto_err_q, proto_err_d;
   logic [31:0]              retired_q, retired_d;
   logic                     retire_s;
   logic [WORD_W-1:0]        restore_pc_s;

   lowest_lane_select #(.NUM_THREADS(NUM_THREADS), .WORD_W(WORD_W)) u_lane_sel (
      .mask_i (mask_q),
      .vec_i  (mem_rsp_data),
      .lane_o (restore_pc_s)
   );

   // Next-state and next-output logic for the packet FSM.
   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      reg_d        = reg_q;
      restore_d    = restore_q;
      rf_wr_en_d   = 1'b0;
      rf_wr_reg_d  = rf_wr_reg_q;
      rf_wr_data_d = rf_wr_data_q;
      rf_wr_mask_d = rf_wr_mask_q;
      mem_valid_d  = mem_valid_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_mask_d   = mem_mask_q;
      fe_valid_d   = fe_valid_q;
      fe_split_d   = fe_split_q;
      fe_pc0_d     = fe_pc0_q;
      fe_pc1_d     = fe_pc1_q;
      fe_mask0_d   = fe_mask0_q;
      fe_mask1_d   = fe_mask1_q;
      halted_d     = halted_q;
      proto_err_d  = proto_err_q | (mem_rsp_valid & (state_q != ST_MEM_WAIT));
      retire_s     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               mask_d    = in_exec_mask;
               reg_d     = in_reg_id;
               restore_d = in_restore_pc;
               if (in_kind == SK_NONE_HALT) begin
                  state_d  = ST_HALTED;
                  halted_d = 1'b1;
                  retire_s = 1'b1;
               end else if (in_kind > SK_STORE_REG_INTO_MEM) begin
                  proto_err_d = 1'b1;
                  retire_s    = 1'b1;
               end else if (in_exec_mask == '0) begin
                  retire_s = 1'b1;
               end else begin
                  case (in_kind)
                     SK_STORE_VALUE_INTO_REG: begin
                        rf_wr_en_d   = 1'b1;
                        rf_wr_reg_d  = in_reg_id;
                        rf_wr_data_d = in_vec_a;
                        rf_wr_mask_d = in_exec_mask;
                        retire_s     = 1'b1;
                     end
                     SK_LOAD_MEM_INTO_REG, SK_STORE_REG_INTO_MEM: begin
                        state_d     = ST_MEM_REQ;
                        mem_valid_d = 1'b1;
                        mem_we_d    = (in_kind == SK_STORE_REG_INTO_MEM);
                        mem_addr_d  = in_vec_a;
                        mem_wdata_d = (in_kind == SK_STORE_REG_INTO_MEM) ? in_vec_b : '0;
                        mem_mask_d  = in_exec_mask;
                     end
                     SK_JMP: begin
                        state_d    = ST_REDIRECT;
                        fe_valid_d = 1'b1;
                        fe_split_d = 1'b0;
                        fe_pc0_d   = in_addr0;
                        fe_mask0_d = in_exec_mask;
                        fe_pc1_d   = '0;
                        fe_mask1_d = '0;
                     end
                     SK_CJMP: begin
                        state_d    = ST_REDIRECT;
                        fe_valid_d = 1'b1;
                        // A target with no lanes collapses the branch to a plain jump.
                        if (in_mask1 == '0) begin
                           fe_split_d = 1'b0;
                           fe_pc0_d   = in_addr0;
                           fe_mask0_d = in_mask0;
                           fe_pc1_d   = '0;
                           fe_mask1_d = '0;
                        end else if (in_mask0 == '0) begin
                           fe_split_d = 1'b0;
                           fe_pc0_d   = in_addr1;
                           fe_mask0_d = in_mask1;
                           fe_pc1_d   = '0;
                           fe_mask1_d = '0;
                        end else begin
                           fe_split_d = 1'b1;
                           fe_pc0_d   = in_addr0;
                           fe_mask0_d = in_mask0;
                           fe_pc1_d   = in_addr1;
                           fe_mask1_d = in_mask1;
                        end
                     end
                     default: begin
                        proto_err_d = 1'b1;
                        retire_s    = 1'b1;
                     end
                  endcase
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MEM_REQ: begin
            if (mem_req_ready) begin
               mem_valid_d = 1'b0;
               state_d     = ST_MEM_WAIT;
            end else begin
               state_d = ST_MEM_REQ;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_rsp_valid) begin
               if (mem_we_q) begin
                  retire_s = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  rf_wr_en_d   = 1'b1;
                  rf_wr_reg_d  = reg_q;
                  rf_wr_data_d = mem_rsp_data;
                  rf_wr_mask_d = mask_q;
                  // A PC restore retires only once fetch takes the new target.
                  if (restore_q) begin
                     state_d    = ST_REDIRECT;
                     fe_valid_d = 1'b1;
                     fe_split_d = 1'b0;
                     fe_pc0_d   = restore_pc_s;
                     fe_mask0_d = mask_q;
                     fe_pc1_d   = '0;
                     fe_mask1_d = '0;
                  end else begin
                     retire_s = 1'b1;
                     state_d  = ST_IDLE;
                  end
               end
            end else begin
               state_d = ST_MEM_WAIT;
            end
         end
         ST_REDIRECT: begin
            if (fetch_ready) begin
               fe_valid_d = 1'b0;
               retire_s   = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               state_d = ST_REDIRECT;
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      retired_d = retired_q + (retire_s ? 32'd1 : 32'd0);
   end

   // State and registered outputs; reset abandons any in-flight transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         mask_q       <= '0;
         reg_q        <= '0;
         restore_q    <= 1'b0;
         rf_wr_en_q   <= 1'b0;
         rf_wr_reg_q  <= '0;
         rf_wr_data_q <= '0;
         rf_wr_mask_q <= '0;
         mem_valid_q  <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_mask_q   <= '0;
         fe_valid_q   <= 1'b0;
         fe_split_q   <= 1'b0;
         fe_pc0_q     <= '0;
         fe_pc1_q     <= '0;
         fe_mask0_q   <= '0;
         fe_mask1_q   <= '0;
         halted_q     <= 1'b0;
         proto_err_q  <= 1'b0;
         retired_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         mask_q       <= mask_d;
         reg_q        <= reg_d;
         restore_q    <= restore_d;
         rf_wr_en_q   <= rf_wr_en_d;
         rf_wr_reg_q  <= rf_wr_reg_d;
         rf_wr_data_q <= rf_wr_data_d;
         rf_wr_mask_q <= rf_wr_mask_d;
         mem_valid_q  <= mem_valid_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_mask_q   <= mem_mask_d;
         fe_valid_q   <= fe_valid_d;
         fe_split_q   <= fe_split_d;
         fe_pc0_q     <= fe_pc0_d;
         fe_pc1_q     <= fe_pc1_d;
         fe_mask0_q   <= fe_mask0_d;
         fe_mask1_q   <= fe_mask1_d;
         halted_q     <= halted_d;
         proto_err_q  <= proto_err_d;
         retired_q    <= retired_d;
      end
   end

   assign in_ready      = (state_q == ST_IDLE);
   assign rf_wr_en      = rf_wr_en_q;
   assign rf_wr_reg     = rf_wr_reg_q;
   assign rf_wr_data    = rf_wr_data_q;
   assign rf_wr_mask    = rf_wr_mask_q;
   assign mem_req_valid = mem_valid_q;
   assign mem_req_we    = mem_we_q;
   assign mem_req_addr  = mem_addr_q;
   assign mem_req_wdata = mem_wdata_q;
   assign mem_req_mask  = mem_mask_q;
   assign fetch_valid   = fe_valid_q;
   assign fetch_split   = fe_split_q;
   assign fetch_pc0     = fe_pc0_q;
   assign fetch_pc1     = fe_pc1_q;
   assign fetch_mask0   = fe_mask0_q;
   assign fetch_mask1   = fe_mask1_q;
   assign halted        = halted_q;
   assign proto_err     = proto_err_q;
   assign retired_cnt   = retired_q;

endmodule
